factorial_core: RTL
===================

# factorial_core

Memory-mapped factorial accelerator acting as bus slave 1, directly downstream of the single-master bus in the 0x7000–0x71FF window. It takes the bus's shared slave address, write-enable and write-data lines plus its own select, and returns read data to the bus mux. A software write of an operand N followed by a start command computes N! with an iterative shift-add multiplier. The 128-bit result (truncated modulo 2^128) is exposed in registers with a done flag and an optional interrupt.

## Interface
- No parameters; the register map and widths are fixed.
- clk  in  1  rising-edge clock shared with the bus.
- reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- s_sel  in  1  slave-1 select from the bus.
- s_wr  in  1  1 = write, 0 = read; qualified by s_sel.
- s_addr  in  16  byte address; only s_addr[7:3] is decoded.
- s_din  in  64  write data.
- s_dout  out  64  read data.
- interrupt  out  1  level interrupt.

## Operation
- Register map (offset = s_addr[7:0]):
  - 0x00 OPSTART: W; bit0=1 starts.
  - 0x08 OPCLEAR: W; bit0=1 aborts and clears.
  - 0x10 OPDONE: R; 2'b00 idle, 2'b10 busy, 2'b11 done.
  - 0x18 INTRENABLE: RW; bit0.
  - 0x20 OPERAND: RW, 64 bits.
  - 0x28 RESULT_H: R.
  - 0x30 RESULT_L: R.
  - All other offsets read 0; writes to them are ignored.
- Write: takes effect at the clk edge where s_sel & s_wr.
- Read: s_dout is combinational from the registers when s_sel & ~s_wr; otherwise s_dout = 0.
- FSM states:
  - IDLE: OPSTART with bit0=1 → LOAD.
  - LOAD: acc=1, cnt=OPERAND. If cnt≤1 → DONE; else → MUL.
  - MUL: 64-cycle shift-add of acc × cnt, low 128 bits kept, 1 bit per cycle. At completion cnt decrements; cnt≥2 → MUL (reloaded the next cycle), else → DONE.
  - DONE: result held; stays until OPCLEAR.
- Busy rules: while in LOAD or MUL, writes to OPERAND and OPSTART are ignored. OPSTART in DONE is also ignored; software must clear first.
- OPCLEAR with bit0=1 in any state → IDLE next cycle. RESULT_H and RESULT_L clear to 0; OPERAND and INTRENABLE are kept.
- Same-edge OPSTART and OPCLEAR are impossible (single bus master, one address per cycle).
- interrupt = INTRENABLE[0] & (state == DONE).

## Timing
- Reset values:
  - s_dout=0, interrupt=0, state IDLE.
  - OPERAND, RESULT_H, RESULT_L = 0; INTRENABLE = 0.
- Reset mid-computation behaves exactly like a power-on reset.
- Latency from the OPSTART write edge to OPDONE reading 2'b11:
  - N ≤ 1: 2 cycles.
  - N ≥ 2: 1 + 65·(N−1) + 1 cycles; each step is 64 multiply cycles plus 1 decrement/reload cycle.
- Results above 34! wrap modulo 2^128 with no error flag.
- interrupt rises in the same cycle OPDONE becomes 2'b11 and falls the cycle after OPCLEAR.

## Configuration
- Macro: FACTORIAL_CORE_INTR_EN.
- Defined: INTRENABLE is implemented and interrupt behaves as above.
- Undefined: INTRENABLE reads 0 and ignores writes; the interrupt port remains and is tied to 0.

## Structure
- Shared package `factorial_pkg`:
  - Register offset constants.
  - FSM state encoding (IDLE, LOAD, MUL, DONE).
  - OPDONE status codes.
  - Slave window bounds 0x7000/0x71FF, also used by the bus decoder.
- Sub-module `shift_add_mul`: 128×64 → 128 sequential multiplier.
  - Inputs: start, operands.
  - Outputs: done pulse, product.
  - Fixed 64-cycle latency.

## Test plan
- Reset, then read all seven offsets → every read returns 0; interrupt=0.
- OPERAND=5, INTRENABLE=1, OPSTART=1 → OPDONE=2'b10 until cycle 262, then 2'b11. RESULT_H=0, RESULT_L=0x78, interrupt=1.
- OPERAND=0, then OPERAND=1, each followed by OPSTART → done after 2 cycles with RESULT_L=1 both times.
- OPERAND=21 → RESULT_H=0x2, RESULT_L=0xC5077D36B8C40000. OPERAND=20 → RESULT_H=0, RESULT_L=0x21C3677C82B40000.
- OPERAND=10, OPSTART, then at cycle 100 write OPERAND=3 and OPSTART again → both writes ignored; final RESULT_L=0x375F00 (10!).
- Mid-run OPCLEAR → next cycle OPDONE=0 and RESULTs=0. Separately, assert reset mid-run → all registers return to 0. Without FACTORIAL_CORE_INTR_EN, INTRENABLE reads 0 and interrupt stays 0 after done.

Source files
------------

// File: rtl/factorial_pkg.sv
`default_nettype none
// =============================================================================
// Module      : factorial_pkg
// Description : Shared constants for the factorial accelerator: register map,
//               FSM encoding, OPDONE status codes and the slave-1 bus window.
// Revision    : 1.0
// =============================================================================
package factorial_pkg;

    localparam logic [15:0] c_SLV1_BASE = 16'h7000;
    localparam logic [15:0] c_SLV1_LAST = 16'h71FF;

    localparam logic [7:0] c_OFF_OPSTART    = 8'h00;
    localparam logic [7:0] c_OFF_OPCLEAR    = 8'h08;
    localparam logic [7:0] c_OFF_OPDONE     = 8'h10;
    localparam logic [7:0] c_OFF_INTRENABLE = 8'h18;
    localparam logic [7:0] c_OFF_OPERAND    = 8'h20;
    localparam logic [7:0] c_OFF_RESULT_H   = 8'h28;
    localparam logic [7:0] c_OFF_RESULT_L   = 8'h30;

    // Only address bits [7:3] are decoded, so registers are indexed by these.
    localparam logic [4:0] c_IDX_OPSTART    = c_OFF_OPSTART[7:3];
    localparam logic [4:0] c_IDX_OPCLEAR    = c_OFF_OPCLEAR[7:3];
    localparam logic [4:0] c_IDX_OPDONE     = c_OFF_OPDONE[7:3];
    localparam logic [4:0] c_IDX_INTRENABLE = c_OFF_INTRENABLE[7:3];
    localparam logic [4:0] c_IDX_OPERAND    = c_OFF_OPERAND[7:3];
    localparam logic [4:0] c_IDX_RESULT_H   = c_OFF_RESULT_H[7:3];
    localparam logic [4:0] c_IDX_RESULT_L   = c_OFF_RESULT_L[7:3];

    localparam logic [1:0] c_STAT_IDLE = 2'b00;
    localparam logic [1:0] c_STAT_BUSY = 2'b10;
    localparam logic [1:0] c_STAT_DONE = 2'b11;

    localparam int c_ACC_W     = 128;
    localparam int c_OPD_W     = 64;
    localparam int c_MUL_STEPS = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } fact_state_t;

    function automatic logic in_slv1_window(input logic [15:0] addr);
        return (addr >= c_SLV1_BASE) && (addr <= c_SLV1_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_mul.sv
`default_nettype none
// =============================================================================
// Module      : shift_add_mul
// Description : 128x64 -> 128 sequential shift-add multiplier, one multiplier
//               bit per cycle, fixed 64-cycle latency from start to done pulse.
// Revision    : 1.0
// =============================================================================
module shift_add_mul
    import factorial_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_start,
    input  logic [c_ACC_W-1:0] i_a,
    input  logic [c_OPD_W-1:0] i_b,
    output logic               o_done,
    output logic [c_ACC_W-1:0] o_product
);

    logic [c_ACC_W-1:0] r_prod;
    logic [c_ACC_W-1:0] r_mcand;
    logic [c_OPD_W-1:0] r_mplier;
    logic [5:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [c_ACC_W-1:0] w_addend;

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign o_done    = r_done;
    assign o_product = r_prod;

    // Bit 0 is folded into the start edge so the done pulse lands 64 cycles later.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_prod   <= i_b[0] ? i_a : '0;
                r_mcand  <= i_a << 1;
                r_mplier <= i_b >> 1;
                r_cnt    <= 6'(c_MUL_STEPS - 1);
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                r_prod   <= r_prod + w_addend;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/factorial_core.sv
`default_nettype none
// =============================================================================
// Module      : factorial_core
// Description : Bus slave computing N! (mod 2^128) with a shift-add multiplier.
//               Define FACTORIAL_CORE_INTR_EN to implement INTRENABLE/interrupt.
// Revision    : 1.0
// =============================================================================
module factorial_core
    import factorial_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        interrupt
);

    fact_state_t        r_state;
    fact_state_t        w_state_nxt;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_OPD_W-1:0] r_cnt;
    logic [c_OPD_W-1:0] r_operand;
    logic               r_load_ph;
    logic               r_mul_go;

    logic [4:0]         w_idx;
    logic               w_wr;
    logic               w_rd;
    logic               w_busy;
    logic               w_wr_start;
    logic               w_wr_clear;
    logic               w_wr_operand;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [c_ACC_W-1:0] w_mul_prod;
    logic [1:0]         w_status;
    logic               w_intr_en;
    logic               w_unused;

    assign w_idx        = s_addr[7:3];
    assign w_wr         = s_sel & s_wr;
    assign w_rd         = s_sel & ~s_wr;
    assign w_busy       = (r_state == ST_LOAD) || (r_state == ST_MUL);
    assign w_wr_start   = w_wr && (w_idx == c_IDX_OPSTART) && s_din[0];
    assign w_wr_clear   = w_wr && (w_idx == c_IDX_OPCLEAR) && s_din[0];
    assign w_wr_operand = w_wr && (w_idx == c_IDX_OPERAND) && !w_busy;
    assign w_mul_start  = (r_state == ST_MUL) && r_mul_go;
    assign w_unused     = ^{s_addr[15:8], s_addr[2:0]};

`ifdef FACTORIAL_CORE_INTR_EN
    logic r_intr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_intr_en <= 1'b0;
        end else if (w_wr && (w_idx == c_IDX_INTRENABLE)) begin
            r_intr_en <= s_din[0];
        end
    end

    assign w_intr_en = r_intr_en;
`else
    assign w_intr_en = 1'b0;
`endif

    assign interrupt = w_intr_en & (r_state == ST_DONE);

    shift_add_mul u_mul (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_wr_clear),
        .i_start   (w_mul_start),
        .i_a       (r_acc),
        .i_b       (r_cnt),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // LOAD spends one cycle loading acc/cnt and one deciding on the loaded count.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_wr_start) w_state_nxt = ST_LOAD;
            ST_LOAD: if (r_load_ph) w_state_nxt = (r_cnt <= 64'd1) ? ST_DONE : ST_MUL;
            ST_MUL:  if (w_mul_done) w_state_nxt = (r_cnt >= 64'd3) ? ST_MUL : ST_DONE;
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_wr_clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_wr_clear) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_load_ph <= 1'b0;
            r_mul_go  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (!r_load_ph) begin
                        r_acc     <= c_ACC_W'(1);
                        r_cnt     <= r_operand;
                        r_load_ph <= 1'b1;
                    end else begin
                        r_load_ph <= 1'b0;
                        r_mul_go  <= (r_cnt > 64'd1);
                    end
                end
                ST_MUL: begin
                    if (w_mul_start) begin
                        r_mul_go <= 1'b0;
                    end
                    if (w_mul_done) begin
                        r_acc    <= w_mul_prod;
                        r_cnt    <= r_cnt - 64'd1;
                        r_mul_go <= (r_cnt >= 64'd3);
                    end
                end
                default: begin
                    r_load_ph <= 1'b0;
                    r_mul_go  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_operand <= '0;
        end else if (w_wr_operand) begin
            r_operand <= s_din;
        end
    end

    always_comb begin
        w_status = c_STAT_IDLE;
        case (r_state)
            ST_LOAD, ST_MUL: w_status = c_STAT_BUSY;
            ST_DONE:         w_status = c_STAT_DONE;
            default:         w_status = c_STAT_IDLE;
        endcase
    end

    always_comb begin
        s_dout = '0;
        if (w_rd) begin
            case (w_idx)
                c_IDX_OPDONE:     s_dout = {62'd0, w_status};
                c_IDX_INTRENABLE: s_dout = {63'd0, w_intr_en};
                c_IDX_OPERAND:    s_dout = r_operand;
                c_IDX_RESULT_H:   s_dout = r_acc[127:64];
                c_IDX_RESULT_L:   s_dout = r_acc[63:0];
                default:          s_dout = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
